keypad_scanner: RTL and testbench

4x4 matrix keypad scanner for the game board. It is the input-side counterpart of the multiplexed 7-segment display driver.
- Drives one keypad column low at a time and samples the four row lines.
- Debounces presses and releases.
- Emits a one-cycle key event with a 4-bit key code to the game control logic.

---
 rtl/keypad_scanner_if.sv | 10 +
 rtl/keypad_scanner.sv | 189 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Key-event bundle from the keypad scanner to the game control logic.
// master drives the event, slave consumes it.
interface keypad_scanner_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (output key_code, key_valid, key_held);
  modport slave  (input  key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sync, debounce, one-cycle key events.
// Define KEYPAD_REPEAT_EN to add auto-repeat pulses while a key stays pressed.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 5000,
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned REPEAT_DELAY = 50,
  parameter int unsigned REPEAT_RATE  = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       row_in,
  output logic [3:0]       col_out,
  keypad_scanner_if.master key_if
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CNT - 1);

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("keypad_scanner: illegal parameter value");
  end

  typedef enum logic [1:0] {StScan, StDebounce, StPressed} state_e;

  state_e          state_q, state_d;
  logic [3:0]      row_meta_q, row_sync_q;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      col_q, col_d;
  logic [1:0]      cap_row_q, cap_row_d;
  logic [CntW-1:0] match_q, match_d;
  logic [CntW-1:0] rel_q, rel_d;
  logic [3:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic            tick, any_low, cap_low, accept;
  logic [1:0]      hit_row;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RepW   = (RepMax > 1) ? $clog2(RepMax) : 1;
  localparam logic [RepW-1:0] DelayLast = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] RateLast  = RepW'(REPEAT_RATE - 1);

  logic [RepW-1:0] rep_q, rep_d;
  logic            rep_first_q, rep_first_d;
`endif

  assign tick    = (div_q == DivLast);
  assign div_d   = tick ? '0 : div_q + 1'b1;
  assign cap_low = ~row_sync_q[cap_row_q];

  // Scan downwards so the lowest active row index is the one left in hit_row.
  always_comb begin
    hit_row = 2'd0;
    any_low = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_sync_q[i]) begin
        hit_row = 2'(i);
        any_low = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    cap_row_d = cap_row_q;
    match_d   = match_q;
    rel_d     = rel_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    accept    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d       = rep_q;
    rep_first_d = rep_first_q;
`endif
    unique case (state_q)
      StScan: begin
        if (tick) begin
          if (any_low) begin
            cap_row_d = hit_row;
            if (DEBOUNCE_CNT == 1) begin
              accept = 1'b1;
            end else begin
              match_d = CntW'(1);
              state_d = StDebounce;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StDebounce: begin
        if (tick) begin
          if (!cap_low) begin
            match_d = '0;
            col_d   = col_q + 1'b1;
            state_d = StScan;
          end else if (match_q == CntLast) begin
            accept = 1'b1;
          end else begin
            match_d = match_q + 1'b1;
          end
        end
      end
      StPressed: begin
        if (tick) begin
          if (cap_low) begin
            rel_d = '0;
`ifdef KEYPAD_REPEAT_EN
            if (rep_q == (rep_first_q ? DelayLast : RateLast)) begin
              valid_d     = 1'b1;
              rep_d       = '0;
              rep_first_d = 1'b0;
            end else begin
              rep_d = rep_q + 1'b1;
            end
`endif
          end else begin
`ifdef KEYPAD_REPEAT_EN
            rep_d = '0;
`endif
            if (rel_q == CntLast) begin
              rel_d   = '0;
              col_d   = col_q + 1'b1;
              state_d = StScan;
            end else begin
              rel_d = rel_q + 1'b1;
            end
          end
        end
      end
      default: state_d = StScan;
    endcase

    if (accept) begin
      code_d  = {cap_row_d, col_q};
      valid_d = 1'b1;
      match_d = '0;
      rel_d   = '0;
      state_d = StPressed;
`ifdef KEYPAD_REPEAT_EN
      rep_d       = '0;
      rep_first_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      row_meta_q <= 4'b1111;
      row_sync_q <= 4'b1111;
      state_q    <= StScan;
      div_q      <= '0;
      col_q      <= 2'd0;
      cap_row_q  <= 2'd0;
      match_q    <= '0;
      rel_q      <= '0;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      row_meta_q <= row_in;
      row_sync_q <= row_meta_q;
      state_q    <= state_d;
      div_q      <= div_d;
      col_q      <= col_d;
      cap_row_q  <= cap_row_d;
      match_q    <= match_d;
      rel_q      <= rel_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
`endif
    end
  end

  assign col_out          = ~(4'b0001 << col_q);
  assign key_if.key_code  = code_q;
  assign key_if.key_valid = valid_q;
  assign key_if.key_held  = (state_q == StPressed);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical 4x4 keypad model plus a cycle-level timing
// model derived from the tick period, sync delay and debounce count.
module tb_keypad_scanner;

  localparam int SD  = 4;
  localparam int DEB = 3;
  localparam int RD  = 8;
  localparam int RR  = 4;
`ifdef KEYPAD_REPEAT_EN
  localparam bit Rep = 1'b1;
`else
  localparam bit Rep = 1'b0;
`endif

  logic        clk, rst;
  logic [15:0] keys;
  logic [3:0]  bounce_mask;
  logic [3:0]  row_in, col_out;
  int          checks, errors, cyc;
  int          idle_col, idle_c0;
  logic [3:0]  last_code;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_DIV    (SD),
    .DEBOUNCE_CNT(DEB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR)
  ) dut (
    .clock  (clk),
    .reset  (rst),
    .row_in (row_in),
    .col_out(col_out),
    .key_if (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Closed switch at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
    row_in = row_in & bounce_mask;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int scan_col(int c);
    return (idle_col + (c - idle_c0) / SD) % 4;
  endfunction

  function automatic int next_tick(int c);
    int t = c;
    while (t % SD != SD - 1) t++;
    return t;
  endfunction

  // Rows reach the sampler two cycles late; the key is seen on a tick of its own column.
  function automatic int capture_tick(int p, int kc);
    int t = next_tick(p + 2);
    while (scan_col(t) != kc) t += SD;
    return t;
  endfunction

  function automatic bit exp_pulse(int c, int a, int l);
    int t, k;
    if (c == a + 1) return 1'b1;
    if (!Rep) return 1'b0;
    t = c - 1;
    if (t % SD != SD - 1 || t <= a || t > l) return 1'b0;
    k = (t - a) / SD;
    return (k >= RD) && ((k - RD) % RR == 0);
  endfunction

  function automatic logic [3:0] col_bits(int c);
    return ~(4'b0001 << c);
  endfunction

  task automatic test_reset();
    keys = '0;
    bounce_mask = 4'hF;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    cyc = 0; idle_col = 0; idle_c0 = 0; last_code = 4'd0;
    checks++;
    if (kif.key_code !== 4'd0) begin
      errors++; $display("FAIL reset_code got=%h exp=0", kif.key_code);
    end
    checks++;
    if (kif.key_held !== 1'b0) begin
      errors++; $display("FAIL reset_held got=%b exp=0", kif.key_held);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (col_out !== col_bits(scan_col(cyc))) begin
        errors++; $display("FAIL reset_col cyc=%0d got=%b exp=%b", cyc, col_out, col_bits(scan_col(cyc)));
      end
      checks++;
      if (kif.key_valid !== 1'b0) begin
        errors++; $display("FAIL reset_valid cyc=%0d got=%b exp=0", cyc, kif.key_valid);
      end
      step();
    end
  endtask

  task automatic test_single_press();
    int p, r, t, a, l, d, npulse, nexp;
    logic [3:0] exp_col, exp_code;
    p = cyc; r = p + 60;
    t = capture_tick(p, 1);
    a = t + SD * (DEB - 1);
    l = next_tick(r + 2) - SD;
    d = next_tick(r + 2) + SD * (DEB - 1) + 1;
    npulse = 0;
    while (cyc <= d) begin
      if (cyc == p) keys[9] = 1'b1;
      if (cyc == r) keys[9] = 1'b0;
      exp_col  = (cyc <= t) ? col_bits(scan_col(cyc)) : col_bits((cyc < d) ? 1 : 2);
      exp_code = (cyc > a) ? 4'd9 : last_code;
      if (kif.key_valid === 1'b1) npulse++;
      checks++;
      if (kif.key_valid !== exp_pulse(cyc, a, l)) begin
        errors++; $display("FAIL single_valid cyc=%0d got=%b exp=%b", cyc, kif.key_valid, exp_pulse(cyc, a, l));
      end
      checks++;
      if (kif.key_held !== (cyc > a && cyc < d)) begin
        errors++; $display("FAIL single_held cyc=%0d got=%b exp=%b", cyc, kif.key_held, (cyc > a && cyc < d));
      end
      checks++;
      if (kif.key_code !== exp_code) begin
        errors++; $display("FAIL single_code cyc=%0d got=%h exp=%h", cyc, kif.key_code, exp_code);
      end
      checks++;
      if (col_out !== exp_col) begin
        errors++; $display("FAIL single_col cyc=%0d got=%b exp=%b", cyc, col_out, exp_col);
      end
      step();
    end
    nexp = 1 + ((Rep && (l - a) / SD >= RD) ? ((l - a) / SD - RD) / RR + 1 : 0);
    checks++;
    if (npulse != nexp) begin
      errors++; $display("FAIL single_count got=%0d exp=%0d", npulse, nexp);
    end
    idle_col = 2; idle_c0 = d; last_code = 4'd9;
  endtask

  task automatic test_bounce();
    int b, t, e;
    logic [3:0] exp_col;
    b = cyc + 1;
    while (scan_col(b) != 0 || b % SD != 1) b++;
    t = b + 2;
    e = t + SD + 1 + 8;
    while (cyc <= e) begin
      bounce_mask = (cyc == b) ? 4'b1110 : 4'b1111;
      if (cyc <= t) exp_col = col_bits(scan_col(cyc));
      else if (cyc <= t + SD) exp_col = col_bits(0);
      else exp_col = col_bits((1 + (cyc - (t + SD + 1)) / SD) % 4);
      checks++;
      if (col_out !== exp_col) begin
        errors++; $display("FAIL bounce_col cyc=%0d got=%b exp=%b", cyc, col_out, exp_col);
      end
      checks++;
      if (kif.key_valid !== 1'b0 || kif.key_held !== 1'b0) begin
        errors++; $display("FAIL bounce_event cyc=%0d got=%b%b exp=00", cyc, kif.key_valid, kif.key_held);
      end
      checks++;
      if (kif.key_code !== last_code) begin
        errors++; $display("FAIL bounce_code cyc=%0d got=%h exp=%h", cyc, kif.key_code, last_code);
      end
      step();
    end
    bounce_mask = 4'hF;
    idle_col = 1; idle_c0 = t + SD + 1;
  endtask

  task automatic test_multi_row();
    int p, r, t, a, l, d, npulse;
    logic [3:0] exp_code;
    p = cyc;
    t = capture_tick(p, 2);
    a = t + SD * (DEB - 1);
    r = a + 1 + SD * 4;
    l = next_tick(r + 2) - SD;
    d = next_tick(r + 2) + SD * (DEB - 1) + 1;
    npulse = 0;
    while (cyc <= d) begin
      if (cyc == p) begin keys[6] = 1'b1; keys[14] = 1'b1; end
      if (cyc == r) begin keys[6] = 1'b0; keys[14] = 1'b0; end
      exp_code = (cyc > a) ? 4'd6 : last_code;
      if (kif.key_valid === 1'b1) npulse++;
      checks++;
      if (kif.key_valid !== exp_pulse(cyc, a, l)) begin
        errors++; $display("FAIL multi_valid cyc=%0d got=%b exp=%b", cyc, kif.key_valid, exp_pulse(cyc, a, l));
      end
      checks++;
      if (kif.key_code !== exp_code) begin
        errors++; $display("FAIL multi_code cyc=%0d got=%h exp=%h", cyc, kif.key_code, exp_code);
      end
      step();
    end
    checks++;
    if (npulse != 1) begin
      errors++; $display("FAIL multi_count got=%0d exp=1", npulse);
    end
    checks++;
    if (col_out !== col_bits(3) || kif.key_held !== 1'b0) begin
      errors++; $display("FAIL multi_release got=%b/%b exp=%b/0", col_out, kif.key_held, col_bits(3));
    end
    idle_col = 3; idle_c0 = d; last_code = 4'd6;
  endtask

  task automatic test_reset_pressed();
    int p, t, a, r, l, d;
    p = cyc;
    t = capture_tick(p, 0);
    a = t + SD * (DEB - 1);
    while (cyc <= a + 4) begin
      if (cyc == p) keys[4] = 1'b1;
      checks++;
      if (kif.key_valid !== (cyc == a + 1) || kif.key_held !== (cyc > a)) begin
        errors++; $display("FAIL rstp_pre cyc=%0d got=%b%b exp=%b%b", cyc, kif.key_valid, kif.key_held,
                           (cyc == a + 1), (cyc > a));
      end
      step();
    end
    rst = 1'b1;
    step();
    checks++;
    if (kif.key_held !== 1'b0 || kif.key_valid !== 1'b0) begin
      errors++; $display("FAIL rstp_flags got=%b%b exp=00", kif.key_held, kif.key_valid);
    end
    checks++;
    if (col_out !== 4'b1110 || kif.key_code !== 4'd0) begin
      errors++; $display("FAIL rstp_state got=%b/%h exp=1110/0", col_out, kif.key_code);
    end
    rst = 1'b0;
    cyc = 0; idle_col = 0; idle_c0 = 0; last_code = 4'd0;
    t = capture_tick(0, 0);
    a = t + SD * (DEB - 1);
    r = a + 1 + SD * 2;
    l = next_tick(r + 2) - SD;
    d = next_tick(r + 2) + SD * (DEB - 1) + 1;
    while (cyc <= d) begin
      if (cyc == r) keys[4] = 1'b0;
      checks++;
      if (kif.key_valid !== exp_pulse(cyc, a, l)) begin
        errors++; $display("FAIL rstp_valid cyc=%0d got=%b exp=%b", cyc, kif.key_valid, exp_pulse(cyc, a, l));
      end
      checks++;
      if (kif.key_held !== (cyc > a && cyc < d)) begin
        errors++; $display("FAIL rstp_held cyc=%0d got=%b exp=%b", cyc, kif.key_held, (cyc > a && cyc < d));
      end
      checks++;
      if (kif.key_code !== ((cyc > a) ? 4'd4 : 4'd0)) begin
        errors++; $display("FAIL rstp_code cyc=%0d got=%h exp=%h", cyc, kif.key_code, (cyc > a) ? 4'd4 : 4'd0);
      end
      step();
    end
    idle_col = 1; idle_c0 = d; last_code = 4'd4;
  endtask

  task automatic test_repeat_random();
    int kc, n, p, t, a, r, l, d, npulse, nexp;
    logic prev_v;
    logic [3:0] exp_col, exp_code;
    for (int it = 0; it < 7; it++) begin
      kc = $urandom_range(15);
      n  = (it == 0) ? 30 : $urandom_range(34, 1);
      p  = cyc + $urandom_range(7);
      t  = capture_tick(p, kc % 4);
      a  = t + SD * (DEB - 1);
      r  = a + 1 + SD * n;
      l  = next_tick(r + 2) - SD;
      d  = next_tick(r + 2) + SD * (DEB - 1) + 1;
      npulse = 0;
      prev_v = 1'b0;
      while (cyc <= d) begin
        if (cyc == p) keys[kc] = 1'b1;
        if (cyc == r) keys[kc] = 1'b0;
        exp_col  = (cyc <= t) ? col_bits(scan_col(cyc)) : col_bits((cyc < d) ? kc % 4 : (kc % 4 + 1) % 4);
        exp_code = (cyc > a) ? 4'(kc) : last_code;
        if (kif.key_valid === 1'b1) npulse++;
        checks++;
        if (kif.key_valid !== exp_pulse(cyc, a, l)) begin
          errors++; $display("FAIL rand_valid it=%0d cyc=%0d got=%b exp=%b", it, cyc, kif.key_valid,
                             exp_pulse(cyc, a, l));
        end
        checks++;
        if (kif.key_held !== (cyc > a && cyc < d) || kif.key_code !== exp_code) begin
          errors++; $display("FAIL rand_held_code it=%0d cyc=%0d got=%b/%h exp=%b/%h", it, cyc, kif.key_held,
                             kif.key_code, (cyc > a && cyc < d), exp_code);
        end
        checks++;
        if (col_out !== exp_col) begin
          errors++; $display("FAIL rand_col it=%0d cyc=%0d got=%b exp=%b", it, cyc, col_out, exp_col);
        end
        if (kif.key_valid === 1'b1) begin
          checks++;
          if (prev_v === 1'b1) begin
            errors++; $display("FAIL rand_double_pulse it=%0d cyc=%0d got=1 exp=0", it, cyc);
          end
        end
        prev_v = kif.key_valid;
        step();
      end
      nexp = 1 + ((Rep && n >= RD) ? (n - RD) / RR + 1 : 0);
      checks++;
      if (npulse != nexp) begin
        errors++; $display("FAIL rand_count it=%0d key=%0d n=%0d got=%0d exp=%0d", it, kc, n, npulse, nexp);
      end
      idle_col = (kc % 4 + 1) % 4; idle_c0 = d; last_code = 4'(kc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0;
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_row();
    test_reset_pressed();
    test_repeat_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
